// File: rtl/laser_scan_ctrl_if.sv
// Candidate/result channel between the LASER scan scheduler and the shared
// point-counting engine.
interface laser_scan_ctrl_if;
  // scan_req is a valid that holds scan_sel/scan_x/scan_y stable until the engine
  // returns a one-cycle scan_ack (with scan_cnt); an ack while scan_req=0 is ignored.
  logic       scan_req;
  logic       scan_sel;
  logic [3:0] scan_x;
  logic [3:0] scan_y;
  logic       scan_ack;
  logic [5:0] scan_cnt;

  modport master (
    output scan_req, scan_sel, scan_x, scan_y,
    input  scan_ack, scan_cnt
  );

  modport slave (
    input  scan_req, scan_sel, scan_x, scan_y,
    output scan_ack, scan_cnt
  );
endinterface

// File: rtl/laser_scan_ctrl.sv
// LASER two-circle candidate-scan scheduler: alternates C1/C2 raster passes, keeps the best union count.
// Optional LASER_SCAN_EARLY_EXIT_EN: a full-coverage result (40) ends the search immediately.
module laser_scan_ctrl #(
  parameter int unsigned MAX_ROUNDS = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  laser_scan_ctrl_if.master         scan,
  output logic [3:0]                C1X,
  output logic [3:0]                C1Y,
  output logic [3:0]                C2X,
  output logic [3:0]                C2Y,
  output logic                      DONE,
  output logic [2:0]                dbg_state_o
);

  // Encoding is visible on dbg_state_o: 0 IDLE, 1 INIT, 2 PASS, 3 COMMIT, 4 CHECK, 5 FINISH.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_PASS   = 3'd2,
    S_COMMIT = 3'd3,
    S_CHECK  = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  localparam logic [3:0] MAX_R = MAX_ROUNDS[3:0];
`ifdef LASER_SCAN_EARLY_EXIT_EN
  localparam logic [5:0] FULL_CNT = 6'd40;
`endif

  state_e     state_q, state_d;
  logic [7:0] cand_q, cand_d;        // {y, x}
  logic       sel_q, sel_d;
  logic [5:0] best_q, best_d;
  logic [7:0] best_xy_q, best_xy_d;
  logic       pass_imp_q, pass_imp_d;
  logic       round_imp_q, round_imp_d;
  logic [3:0] round_q, round_d;
  logic [7:0] c1_q, c1_d;            // {y, x}
  logic [7:0] c2_q, c2_d;
`ifdef LASER_SCAN_EARLY_EXIT_EN
  logic       early_q, early_d;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    sel_d       = sel_q;
    best_d      = best_q;
    best_xy_d   = best_xy_q;
    pass_imp_d  = pass_imp_q;
    round_imp_d = round_imp_q;
    round_d     = round_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
`ifdef LASER_SCAN_EARLY_EXIT_EN
    early_d     = early_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        c1_d        = 8'h00;
        c2_d        = 8'hFF;
        best_d      = 6'd0;
        best_xy_d   = 8'h00;
        round_d     = 4'd0;
        sel_d       = 1'b0;
        pass_imp_d  = 1'b0;
        round_imp_d = 1'b0;
        cand_d      = 8'h00;
`ifdef LASER_SCAN_EARLY_EXIT_EN
        early_d     = 1'b0;
`endif
        state_d     = S_PASS;
      end
      S_PASS: begin
        if (scan.scan_ack) begin
          // Strict compare: a tie keeps the earlier raster position.
          if (scan.scan_cnt > best_q) begin
            best_d      = scan.scan_cnt;
            best_xy_d   = cand_q;
            pass_imp_d  = 1'b1;
            round_imp_d = 1'b1;
          end
`ifdef LASER_SCAN_EARLY_EXIT_EN
          if (scan.scan_cnt == FULL_CNT) begin
            early_d = 1'b1;
            state_d = S_COMMIT;
          end else
`endif
          if (cand_q == 8'hFF) state_d = S_COMMIT;
          else                 cand_d  = cand_q + 8'd1;
        end
      end
      S_COMMIT: begin
        if (pass_imp_q) begin
          if (sel_q) c2_d = best_xy_q;
          else       c1_d = best_xy_q;
        end
        pass_imp_d = 1'b0;
        cand_d     = 8'h00;
`ifdef LASER_SCAN_EARLY_EXIT_EN
        if (early_q) state_d = S_FINISH;
        else
`endif
        if (!sel_q) begin
          sel_d   = 1'b1;
          state_d = S_PASS;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        round_d = round_q + 4'd1;
        if (!round_imp_q || ((round_q + 4'd1) == MAX_R)) begin
          state_d = S_FINISH;
        end else begin
          sel_d       = 1'b0;
          round_imp_d = 1'b0;
          state_d     = S_PASS;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cand_q      <= 8'h00;
      sel_q       <= 1'b0;
      best_q      <= 6'd0;
      best_xy_q   <= 8'h00;
      pass_imp_q  <= 1'b0;
      round_imp_q <= 1'b0;
      round_q     <= 4'd0;
      c1_q        <= 8'h00;
      c2_q        <= 8'h00;
`ifdef LASER_SCAN_EARLY_EXIT_EN
      early_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      sel_q       <= sel_d;
      best_q      <= best_d;
      best_xy_q   <= best_xy_d;
      pass_imp_q  <= pass_imp_d;
      round_imp_q <= round_imp_d;
      round_q     <= round_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
`ifdef LASER_SCAN_EARLY_EXIT_EN
      early_q     <= early_d;
`endif
    end
  end

  // Request follows the state directly so a reset drops it in the very next cycle.
  assign scan.scan_req = (state_q == S_PASS);
  assign scan.scan_sel = sel_q;
  assign scan.scan_x   = cand_q[3:0];
  assign scan.scan_y   = cand_q[7:4];
  assign C1X           = c1_q[3:0];
  assign C1Y           = c1_q[7:4];
  assign C2X           = c2_q[3:0];
  assign C2Y           = c2_q[7:4];
  assign DONE          = (state_q == S_FINISH);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Self-checking bench for laser_scan_ctrl: table-driven engine model plus a loop-level reference of the search.
module tb_laser_scan_ctrl;
  localparam int TB_MAX = 3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [3:0] c1x, c1y, c2x, c2y;
  logic       done;
  logic [2:0] dbg;

  laser_scan_ctrl_if bus();

  laser_scan_ctrl #(.MAX_ROUNDS(TB_MAX)) dut (
    .CLK(CLK), .RST(RST), .start(start), .scan(bus),
    .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y),
    .DONE(done), .dbg_state_o(dbg)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_check = 0;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (dbg === ST_CHECK) n_check++;

  // Per-pass engine response and ack latency, indexed by raster position y*16+x.
  logic [5:0] resp[6][256];
  int         lat[6][256];

  int run_id = 0;
  int eng_run = -1, eng_pass = 0, eng_idx = 0, eng_wait = 0;
  int raster_bad = 0;
  bit stray_req = 1'b0;

  always @(negedge CLK) begin
    bus.scan_ack = 1'b0;
    bus.scan_cnt = 6'($urandom_range(0, 63));
    if (eng_run != run_id) begin
      eng_run = run_id; eng_pass = 0; eng_idx = 0; eng_wait = 0;
    end
    if (stray_req) begin
      bus.scan_ack = 1'b1;
      bus.scan_cnt = 6'd40;
    end else if (bus.scan_req === 1'b1) begin
      if (eng_pass > 5) begin
        raster_bad++;
      end else if (eng_wait >= lat[eng_pass][eng_idx]) begin
        if ({bus.scan_sel, bus.scan_y, bus.scan_x} !== {eng_pass[0], eng_idx[7:0]}) raster_bad++;
        bus.scan_ack = 1'b1;
        bus.scan_cnt = resp[eng_pass][eng_idx];
        eng_wait = 0;
        eng_idx++;
        if (eng_idx == 256) begin eng_idx = 0; eng_pass++; end
      end else begin
        eng_wait++;
      end
    end else begin
      eng_wait = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int vmax, input int lmin, input int lmax);
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 256; i++) begin
        resp[p][i] = 6'($urandom_range(0, vmax));
        lat[p][i]  = $urandom_range(lmin, lmax);
      end
  endtask

  // Reference search: expected {C1X,C1Y,C2X,C2Y}, cycles from the start cycle to DONE, CHECK visits.
  task automatic model(output logic [15:0] exp_c, output int exp_cycles, output int exp_checks);
    logic [7:0] c1, c2, bxy;
    int best, p, cycles;
    bit rimp, pimp, stop, early;
    c1 = 8'h00; c2 = 8'hFF; best = 0; p = 0; cycles = 1; exp_checks = 0; stop = 1'b0;
    for (int r = 0; r < TB_MAX && !stop; r++) begin
      rimp = 1'b0;
      for (int s = 0; s < 2 && !stop; s++) begin
        pimp = 1'b0; early = 1'b0; bxy = 8'h00;
        for (int i = 0; i < 256 && !early; i++) begin
          cycles += lat[p][i] + 1;
          if (int'(resp[p][i]) > best) begin
            best = int'(resp[p][i]); bxy = i[7:0]; pimp = 1'b1;
          end
`ifdef LASER_SCAN_EARLY_EXIT_EN
          if (resp[p][i] == 6'd40) early = 1'b1;
`endif
        end
        cycles += 1;
        if (pimp) begin
          if (s == 0) c1 = bxy; else c2 = bxy;
        end
        rimp |= pimp;
        p++;
        if (early) stop = 1'b1;
      end
      if (!stop) begin
        cycles += 1;
        exp_checks++;
        if (!rimp || (r + 1) == TB_MAX) stop = 1'b1;
      end
    end
    cycles += 1;
    exp_c = {c1[3:0], c1[7:4], c2[3:0], c2[7:4]};
    exp_cycles = cycles;
  endtask

  task automatic run_and_check(input string tag, input bit poke);
    logic [15:0] exp_c;
    int exp_cycles, exp_checks, k, chk0, rb0, n;
    model(exp_c, exp_cycles, exp_checks);
    run_id++;
    chk0 = n_check; rb0 = raster_bad;
    @(posedge CLK); #1 start = 1'b1; k = cyc;
    @(posedge CLK); #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(posedge CLK); #1;
      n++;
      start = (poke && n == 100);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc - k), 32'(exp_cycles));
    chk({tag, "_centres"}, {16'd0, c1x, c1y, c2x, c2y}, {16'd0, exp_c});
    chk({tag, "_check_visits"}, 32'(n_check - chk0), 32'(exp_checks));
    chk({tag, "_raster_order"}, 32'(raster_bad - rb0), 32'd0);
    @(posedge CLK); #1;
    chk({tag, "_done_pulse"}, {30'd0, done, bus.scan_req}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 chk({tag, "_hold"}, {13'd0, dbg, c1x, c1y, c2x, c2y}, {13'd0, ST_IDLE, exp_c});
  endtask

  initial begin
    int n;
    RST = 1'b1; start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs",
        {13'd0, bus.scan_req, bus.scan_sel, bus.scan_x, bus.scan_y, c1x, c1y, c2x, c2y, done},
        32'd0);
    chk("reset_state", 32'(dbg), 32'(ST_IDLE));
    RST = 1'b0;

    // All-zero engine with fixed 3-cycle ack latency: one round, initial centres.
    fill(0, 3, 3);
    run_and_check("zero_engine", 1'b0);

    // Single hit per circle; round 2 finds nothing better. Mid-run start is ignored.
    fill(0, 0, 3);
    for (int p = 0; p < 6; p += 2) begin
      resp[p][6*16+5]   = 6'd12;
      resp[p+1][3*16+9] = 6'd20;
    end
    run_and_check("two_hits", 1'b1);

    // Tie at (2,1) and (8,1) in the C1 pass: earlier raster position wins.
    fill(0, 0, 2);
    for (int p = 0; p < 6; p += 2) begin
      resp[p][1*16+2] = 6'd7;
      resp[p][1*16+8] = 6'd7;
    end
    run_and_check("tie", 1'b0);

    // Every pass improves: stops on the round limit after three CHECKs.
    fill(0, 0, 2);
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) resp[p][i] = 6'($urandom_range(0, 6*p));
      resp[p][$urandom_range(0, 255)] = 6'(6*p + $urandom_range(1, 5));
    end
    run_and_check("round_limit", 1'b0);

    // Reset in the middle of the C2 pass at (7,4) with an ack still pending.
    fill(0, 3, 3);
    run_id++;
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    n = 0;
    while (!(bus.scan_req === 1'b1 && bus.scan_sel === 1'b1 && bus.scan_x === 4'd7 &&
             bus.scan_y === 4'd4) && n < 5000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("rst_reach_7_4", 32'(n < 5000), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_outputs",
        {13'd0, bus.scan_req, bus.scan_sel, bus.scan_x, bus.scan_y, c1x, c1y, c2x, c2y, done},
        32'd0);
    chk("rst_state", 32'(dbg), 32'(ST_IDLE));
    @(posedge CLK); #1 stray_req = 1'b1;
    @(posedge CLK); #1 stray_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("rst_stray_ack",
           {16'd0, dbg, bus.scan_req, done, c1x, c1y, c2x, c2y[3:1]},
           32'd0);

    // Randomized engines, including counts above 40.
    fill(63, 0, 3);
    run_and_check("rand_wide", 1'b0);
    fill(40, 0, 2);
    run_and_check("rand_40", 1'b0);

`ifdef LASER_SCAN_EARLY_EXIT_EN
    fill(0, 3, 3);
    resp[0][3*16+3] = 6'd40;
    run_and_check("early_exit", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
